// File: rtl/game_ctrl_fsm_if.sv
// Datapath handshake bundle between game_ctrl_fsm and the 1A2B compare datapath.
// The controller uses the master side; the datapath uses the slave side.
interface game_ctrl_fsm_if #(
    parameter int CW = 3
);
    logic          reset;
    logic          save_test;
    logic          save_guess;
    logic          cmp_start;
    logic          dp_valid;
    logic [CW-1:0] dp_a;
    logic [CW-1:0] dp_b;
    logic          dp_input_error;

    modport master (
        output reset, save_test, save_guess, cmp_start,
        input  dp_valid, dp_a, dp_b, dp_input_error
    );

    modport slave (
        input  reset, save_test, save_guess, cmp_start,
        output dp_valid, dp_a, dp_b, dp_input_error
    );
endinterface

// File: rtl/game_ctrl_fsm.sv
// 1A2B game controller: secret load, guess entry, compare handshake with timeout,
// try counting and win/lose reporting. Define GAME_TRY_LIMIT_EN to enable LOSE.
module game_ctrl_fsm #(
    parameter int  DIGITS      = 4,
    parameter int  MAX_TRIES   = 10,
    parameter int  CMP_TIMEOUT = 15,
    localparam int CW          = $clog2(DIGITS + 1),
    localparam int TW          = $clog2(MAX_TRIES + 1)
) (
    input  logic                   clka,
    input  logic                   restart,
    input  logic                   loadtest,
    input  logic                   enter,
    game_ctrl_fsm_if.master        dp,
    output logic                   same,
    output logic                   lose,
    output logic                   input_error,
    output logic [CW-1:0]          a_cnt,
    output logic [CW-1:0]          b_cnt,
    output logic [TW-1:0]          tries,
    output logic [2:0]             state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_LOAD  = 3'b001,
        ST_GUESS = 3'b010,
        ST_CMP   = 3'b011,
        ST_WIN   = 3'b100,
        ST_LOSE  = 3'b101
    } state_t;

    // Counter is loaded one below the budget so the last waiting edge sees zero.
    localparam logic [7:0]    TMO_LOAD = 8'(CMP_TIMEOUT - 1);
    localparam logic [CW-1:0] A_WIN    = CW'(DIGITS);
`ifdef GAME_TRY_LIMIT_EN
    localparam logic [TW-1:0] TRY_SAT  = TW'(MAX_TRIES);
`else
    localparam logic [TW-1:0] TRY_SAT  = {TW{1'b1}};
`endif

    state_t        state_r;
    logic [7:0]    tmo_r;
    logic [TW-1:0] tries_inc_s;

    assign state = state_r;

    // Saturating try increment.
    always_comb begin
        tries_inc_s = tries;
        if (tries == TRY_SAT) begin
            tries_inc_s = tries;
        end else begin
            tries_inc_s = tries + TW'(1);
        end
    end

    // Control FSM with registered strobes and result flags.
    always_ff @(negedge clka) begin
        if (restart) begin
            state_r        <= ST_IDLE;
            tmo_r          <= 8'd0;
            dp.reset       <= 1'b1;
            dp.save_test   <= 1'b0;
            dp.save_guess  <= 1'b0;
            dp.cmp_start   <= 1'b0;
            same           <= 1'b0;
            lose           <= 1'b0;
            input_error    <= 1'b0;
            a_cnt          <= '0;
            b_cnt          <= '0;
            tries          <= '0;
        end else begin
            dp.reset      <= 1'b0;
            dp.save_test  <= 1'b0;
            dp.save_guess <= 1'b0;
            dp.cmp_start  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    same        <= 1'b0;
                    lose        <= 1'b0;
                    input_error <= 1'b0;
                    a_cnt       <= '0;
                    b_cnt       <= '0;
                    tries       <= '0;
                    state_r     <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (loadtest) begin
                        dp.save_test <= 1'b1;
                        state_r      <= ST_GUESS;
                    end
                end
                ST_GUESS: begin
                    if (enter) begin
                        dp.save_guess <= 1'b1;
                        dp.cmp_start  <= 1'b1;
                        input_error   <= 1'b0;
                        tmo_r         <= TMO_LOAD;
                        state_r       <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    // A result on the final waiting edge wins over the timeout.
                    if (dp.dp_valid) begin
                        if (dp.dp_input_error) begin
                            input_error <= 1'b1;
                            state_r     <= ST_GUESS;
                        end else begin
                            a_cnt <= dp.dp_a;
                            b_cnt <= dp.dp_b;
                            tries <= tries_inc_s;
                            if (dp.dp_a == A_WIN) begin
                                same    <= 1'b1;
                                state_r <= ST_WIN;
                            end else begin
`ifdef GAME_TRY_LIMIT_EN
                                if (tries_inc_s == TW'(MAX_TRIES)) begin
                                    lose    <= 1'b1;
                                    state_r <= ST_LOSE;
                                end else begin
                                    state_r <= ST_GUESS;
                                end
`else
                                state_r <= ST_GUESS;
`endif
                            end
                        end
                    end else if (tmo_r == 8'd0) begin
                        input_error <= 1'b1;
                        state_r     <= ST_GUESS;
                    end else begin
                        tmo_r <= tmo_r - 8'd1;
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (enter) begin
                        dp.reset    <= 1'b1;
                        same        <= 1'b0;
                        lose        <= 1'b0;
                        input_error <= 1'b0;
                        a_cnt       <= '0;
                        b_cnt       <= '0;
                        tries       <= '0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    dp.reset <= 1'b1;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Self-checking bench for game_ctrl_fsm: cycle model compared every cycle plus
// hand-computed checkpoints. Runs with or without GAME_TRY_LIMIT_EN.
module tb_game_ctrl_fsm;

    localparam int DIGITS      = 4;
    localparam int MAX_TRIES   = 3;
    localparam int CMP_TIMEOUT = 15;
    localparam int CW          = $clog2(DIGITS + 1);
    localparam int TW          = $clog2(MAX_TRIES + 1);
`ifdef GAME_TRY_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
    localparam int TRY_SAT  = MAX_TRIES;
`else
    localparam bit LIMIT_EN = 1'b0;
    localparam int TRY_SAT  = (1 << TW) - 1;
`endif

    logic          clka = 1'b1;
    logic          restart = 1'b1;
    logic          loadtest = 1'b0;
    logic          enter = 1'b0;
    logic          same, lose, input_error;
    logic [CW-1:0] a_cnt, b_cnt;
    logic [TW-1:0] tries;
    logic [2:0]    state;

    game_ctrl_fsm_if #(.CW(CW)) dp_if ();

    game_ctrl_fsm #(
        .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .CMP_TIMEOUT(CMP_TIMEOUT)
    ) dut (
        .clka(clka), .restart(restart), .loadtest(loadtest), .enter(enter),
        .dp(dp_if.master), .same(same), .lose(lose), .input_error(input_error),
        .a_cnt(a_cnt), .b_cnt(b_cnt), .tries(tries), .state(state)
    );

    always #5 clka = ~clka;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int sg_cnt = 0;
    int cs_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: game rules evaluated at each active (falling) edge.
    int m_state = 0, m_tries = 0, m_a = 0, m_b = 0, m_wait = 0;
    bit m_reset = 1'b1, m_st, m_sg, m_cs, m_same, m_lose, m_err;

    always @(negedge clka) begin
        m_st = 1'b0; m_sg = 1'b0; m_cs = 1'b0; m_reset = 1'b0;
        if (restart) begin
            m_state = 0; m_reset = 1'b1; m_tries = 0; m_a = 0; m_b = 0;
            m_same = 1'b0; m_lose = 1'b0; m_err = 1'b0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: if (loadtest) begin m_st = 1'b1; m_state = 2; end
                2: if (enter) begin
                       m_sg = 1'b1; m_cs = 1'b1; m_err = 1'b0; m_wait = 0; m_state = 3;
                   end
                3: begin
                    m_wait = m_wait + 1;
                    if (dp_if.dp_valid) begin
                        if (dp_if.dp_input_error) begin
                            m_err = 1'b1; m_state = 2;
                        end else begin
                            m_a = int'(dp_if.dp_a);
                            m_b = int'(dp_if.dp_b);
                            m_tries = (m_tries + 1 > TRY_SAT) ? TRY_SAT : m_tries + 1;
                            if (m_a == DIGITS) begin
                                m_same = 1'b1; m_state = 4;
                            end else if (LIMIT_EN && m_tries == MAX_TRIES) begin
                                m_lose = 1'b1; m_state = 5;
                            end else begin
                                m_state = 2;
                            end
                        end
                    end else if (m_wait == CMP_TIMEOUT) begin
                        m_err = 1'b1; m_state = 2;
                    end
                end
                default: if (enter) begin
                    m_reset = 1'b1; m_state = 0; m_tries = 0; m_a = 0; m_b = 0;
                    m_same = 1'b0; m_lose = 1'b0; m_err = 1'b0;
                end
            endcase
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(posedge clka) begin
        if (chk_en) begin
            chk("state",       int'(state),            m_state);
            chk("reset",       int'(dp_if.reset),      int'(m_reset));
            chk("save_test",   int'(dp_if.save_test),  int'(m_st));
            chk("save_guess",  int'(dp_if.save_guess), int'(m_sg));
            chk("cmp_start",   int'(dp_if.cmp_start),  int'(m_cs));
            chk("same",        int'(same),             int'(m_same));
            chk("lose",        int'(lose),             int'(m_lose));
            chk("input_error", int'(input_error),      int'(m_err));
            chk("a_cnt",       int'(a_cnt),            m_a);
            chk("b_cnt",       int'(b_cnt),            m_b);
            chk("tries",       int'(tries),            m_tries);
        end
    end

    always @(negedge clka) begin
        #1;
        if (dp_if.save_guess === 1'b1) sg_cnt++;
        if (dp_if.cmp_start === 1'b1) cs_cnt++;
    end

    task automatic cyc();
        @(posedge clka);
    endtask

    task automatic drive_dp(input bit v, input int a, input int b, input bit e);
        dp_if.dp_valid       = v;
        dp_if.dp_a           = CW'(a);
        dp_if.dp_b           = CW'(b);
        dp_if.dp_input_error = e;
    endtask

    task automatic press_enter();
        enter = 1'b1; cyc(); enter = 1'b0;
    endtask

    task automatic press_load();
        loadtest = 1'b1; cyc(); loadtest = 1'b0;
    endtask

    task automatic result(input int a, input int b, input bit e);
        drive_dp(1'b1, a, b, e); cyc(); drive_dp(1'b0, 0, 0, 1'b0);
    endtask

    int sg0, cs0;

    initial begin
        drive_dp(1'b0, 0, 0, 1'b0);
        cyc();
        chk_en = 1'b1;
        chk("rst_state", int'(state), 0);
        chk("rst_reset", int'(dp_if.reset), 1);
        chk("rst_tries", int'(tries), 0);
        restart = 1'b0;
        cyc();
        chk("load_state", int'(state), 1);
        press_enter();
        chk("load_ignores_enter", int'(state), 1);

        // Normal win
        press_load();
        chk("guess_state", int'(state), 2);
        chk("save_test_pulse", int'(dp_if.save_test), 1);
        press_load();
        chk("guess_ignores_load", int'(state), 2);
        press_enter();
        chk("cmp_state", int'(state), 3);
        result(4, 0, 1'b0);
        chk("win_same", int'(same), 1);
        chk("win_state", int'(state), 4);
        chk("win_tries", int'(tries), 1);
        chk("win_a", int'(a_cnt), 4);
        press_enter();
        chk("idle_state", int'(state), 0);
        chk("idle_reset", int'(dp_if.reset), 1);
        chk("idle_tries", int'(tries), 0);
        cyc();
        chk("idle_one_cycle", int'(state), 1);

        // Miss
        press_load();
        sg0 = sg_cnt; cs0 = cs_cnt;
        press_enter();
        result(1, 2, 1'b0);
        chk("miss_a", int'(a_cnt), 1);
        chk("miss_b", int'(b_cnt), 2);
        chk("miss_tries", int'(tries), 1);
        chk("miss_state", int'(state), 2);
        chk("miss_sg_once", sg_cnt - sg0, 1);
        chk("miss_cs_once", cs_cnt - cs0, 1);

        // Input error, then cleared by the next enter
        press_enter();
        result(3, 1, 1'b1);
        chk("err_flag", int'(input_error), 1);
        chk("err_tries", int'(tries), 1);
        chk("err_a_held", int'(a_cnt), 1);
        press_enter();
        chk("err_cleared", int'(input_error), 0);
        result(0, 3, 1'b0);
        chk("miss2_tries", int'(tries), 2);

        // Timeout: 15 waiting cycles then back to GUESS
        press_enter();
        repeat (14) cyc();
        chk("tmo_still_cmp", int'(state), 3);
        cyc();
        chk("tmo_state", int'(state), 2);
        chk("tmo_err", int'(input_error), 1);
        chk("tmo_tries", int'(tries), 2);

        // Result on the final waiting cycle is accepted (third miss)
        press_enter();
        repeat (14) cyc();
        result(2, 2, 1'b0);
        chk("late_tries", int'(tries), 3);
        chk("late_err", int'(input_error), 0);
`ifdef GAME_TRY_LIMIT_EN
        chk("lose_flag", int'(lose), 1);
        chk("lose_state", int'(state), 5);
        press_enter();
        chk("lose_idle", int'(state), 0);
        chk("lose_idle_reset", int'(dp_if.reset), 1);
        chk("lose_idle_tries", int'(tries), 0);
        chk("lose_idle_lose", int'(lose), 0);
`else
        chk("nolimit_state", int'(state), 2);
        chk("nolimit_lose", int'(lose), 0);
        press_enter();
        result(1, 1, 1'b0);
        chk("sat_tries", int'(tries), 3);
        press_enter();
        result(4, 3, 1'b0);
        chk("sat_win_state", int'(state), 4);
        chk("sat_win_b", int'(b_cnt), 3);
        press_enter();
        chk("win_idle", int'(state), 0);
`endif

        // Out-of-range counts, then restart mid-CMP with a simultaneous enter
        cyc();
        press_load();
        press_enter();
        result(5, 6, 1'b0);
        chk("oor_a", int'(a_cnt), 5);
        chk("oor_b", int'(b_cnt), 6);
        press_enter();
        restart = 1'b1; enter = 1'b1;
        cyc();
        restart = 1'b0; enter = 1'b0;
        chk("rs_state", int'(state), 0);
        chk("rs_reset", int'(dp_if.reset), 1);
        chk("rs_tries", int'(tries), 0);
        chk("rs_cmp_start", int'(dp_if.cmp_start), 0);
        cyc();
        chk("rs_load", int'(state), 1);
        cyc();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
